// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches, data loads and data
// stores onto a single 8-bit RAM port with registered address and write strobe.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instruction_read_flag,
    input  logic [31:0] instruction_read_address,
    output logic        instruction_flag,
    output logic [31:0] instruction,
    input  logic        data_read_flag,
    input  logic        data_write_flag,
    input  logic [31:0] data_address,
    input  logic [1:0]  data_len,
    input  logic [31:0] data_write_value,
    output logic        data_flag,
    output logic [31:0] data_value,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] base, base_next;
    logic [2:0]  len, len_next;
    logic [2:0]  cnt, cnt_next;
    logic [31:0] wdata, wdata_next;
    logic [31:0] rdata, rdata_next;
    logic        fetch, fetch_next;
    logic        instruction_flag_next, data_flag_next, mem_wr_next;
    logic [31:0] instruction_next, data_value_next, mem_a_next;
    logic [7:0]  mem_dout_next;
    logic [1:0]  rd_idx, wr_idx;
    logic        fetch_abort;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            2'd0:    byte_count = 3'd1;
            2'd1:    byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

    // cnt holds the number of the upcoming edge counted from acceptance; the byte
    // arriving on mem_din belongs to the address issued one edge earlier.
    assign rd_idx = cnt[1:0] - 2'd1;
    assign wr_idx = cnt[1:0];
    assign fetch_abort = fetch && (!instruction_read_flag || (instruction_read_address != base));

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            base             <= '0;
            len              <= '0;
            cnt              <= '0;
            wdata            <= '0;
            rdata            <= '0;
            fetch            <= 1'b0;
            instruction_flag <= 1'b0;
            instruction      <= '0;
            data_flag        <= 1'b0;
            data_value       <= '0;
            mem_dout         <= '0;
            mem_a            <= '0;
            mem_wr           <= 1'b0;
        end else begin
            state            <= state_next;
            base             <= base_next;
            len              <= len_next;
            cnt              <= cnt_next;
            wdata            <= wdata_next;
            rdata            <= rdata_next;
            fetch            <= fetch_next;
            instruction_flag <= instruction_flag_next;
            instruction      <= instruction_next;
            data_flag        <= data_flag_next;
            data_value       <= data_value_next;
            mem_dout         <= mem_dout_next;
            mem_a            <= mem_a_next;
            mem_wr           <= mem_wr_next;
        end
    end

    always_comb begin
        state_next            = state;
        base_next             = base;
        len_next              = len;
        cnt_next              = cnt;
        wdata_next            = wdata;
        rdata_next            = rdata;
        fetch_next            = fetch;
        instruction_flag_next = 1'b0;
        instruction_next      = instruction;
        data_flag_next        = 1'b0;
        data_value_next       = data_value;
        mem_dout_next         = mem_dout;
        mem_a_next            = mem_a;
        mem_wr_next           = 1'b0;

        case (state)
            IDLE: begin
                if (data_write_flag) begin
                    base_next     = data_address;
                    len_next      = byte_count(data_len);
                    wdata_next    = data_write_value;
                    fetch_next    = 1'b0;
                    cnt_next      = 3'd1;
                    mem_a_next    = data_address;
                    mem_dout_next = data_write_value[7:0];
                    mem_wr_next   = 1'b1;
                    state_next    = WRITE;
                end else if (data_read_flag) begin
                    base_next  = data_address;
                    len_next   = byte_count(data_len);
                    fetch_next = 1'b0;
                    cnt_next   = 3'd1;
                    rdata_next = '0;
                    mem_a_next = data_address;
                    state_next = READ;
                end else if (instruction_read_flag) begin
                    base_next  = instruction_read_address;
                    len_next   = 3'd4;
                    fetch_next = 1'b1;
                    cnt_next   = 3'd1;
                    rdata_next = '0;
                    mem_a_next = instruction_read_address;
                    state_next = READ;
                end
            end

            READ: begin
                if (fetch_abort) begin
                    state_next = IDLE;
                end else begin
                    rdata_next[{rd_idx, 3'b000} +: 8] = mem_din;
                    if (cnt == len) begin
                        if (fetch) begin
                            instruction_flag_next = 1'b1;
                            instruction_next      = rdata_next;
                        end else begin
                            data_flag_next  = 1'b1;
                            data_value_next = rdata_next;
                        end
                        state_next = DONE;
                    end else begin
                        mem_a_next = base + {29'd0, cnt};
                        cnt_next   = cnt + 3'd1;
                    end
                end
            end

            WRITE: begin
                if (cnt == len) begin
                    data_flag_next = 1'b1;
                    state_next     = DONE;
                end else begin
                    mem_a_next    = base + {29'd0, cnt};
                    mem_dout_next = wdata[{wr_idx, 3'b000} +: 8];
                    mem_wr_next   = 1'b1;
                    cnt_next      = cnt + 3'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-addressed RAM model on the RAM port, a transaction-level
// reference memory, and a per-cycle compare of completions against expected results.
module tb_mem_ctrl;
    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int NINIT   = 22;
    localparam logic [31:0] INIT_A [NINIT] = '{
        32'h100, 32'h101, 32'h102, 32'h103, 32'h20, 32'h21, 32'h22, 32'h23,
        32'h30, 32'h31, 32'h32, 32'h33, 32'h200, 32'h201, 32'h202, 32'h203,
        32'h300, 32'h301, 32'h302, 32'h303, 32'hFFFF_FFFF, 32'h0};
    localparam logic [7:0] INIT_D [NINIT] = '{
        8'h13, 8'h05, 8'h10, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
        8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04,
        8'h93, 8'h00, 8'hA0, 8'h00, 8'hAB, 8'hCD};

    typedef struct {
        int          kind;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instruction_read_flag;
    logic [31:0] instruction_read_address;
    logic        instruction_flag;
    logic [31:0] instruction;
    logic        data_read_flag;
    logic        data_write_flag;
    logic [31:0] data_address;
    logic [1:0]  data_len;
    logic [31:0] data_write_value;
    logic        data_flag;
    logic [31:0] data_value;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  ram [bit [31:0]];
    logic [7:0]  model_ram [bit [31:0]];
    exp_t        exp_q [$];
    exp_t        cmp_e;
    int          tests = 0;
    int          fails = 0;
    int          wr_count = 0;
    bit          armed = 1'b0;
    bit          rst_seen = 1'b0;
    logic [31:0] last_instr = '0;
    logic [31:0] last_data = '0;

    mem_ctrl dut (
        .clk                      (clk),
        .rst                      (rst),
        .instruction_read_flag    (instruction_read_flag),
        .instruction_read_address (instruction_read_address),
        .instruction_flag         (instruction_flag),
        .instruction              (instruction),
        .data_read_flag           (data_read_flag),
        .data_write_flag          (data_write_flag),
        .data_address             (data_address),
        .data_len                 (data_len),
        .data_write_value         (data_write_value),
        .data_flag                (data_flag),
        .data_value               (data_value),
        .mem_din                  (mem_din),
        .mem_dout                 (mem_dout),
        .mem_a                    (mem_a),
        .mem_wr                   (mem_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] model_rd(input bit [31:0] a);
        return model_ram.exists(a) ? model_ram[a] : 8'h00;
    endfunction

    function automatic int nbytes(input int kind, input logic [1:0] l);
        if (kind == K_FETCH) return 4;
        return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM: address registered by the DUT, read data presented before the next edge.
    always @(posedge clk) begin
        if (!armed) for (int i = 0; i < NINIT; i++) ram[INIT_A[i]] = INIT_D[i];
        armed = 1'b1;
        rst_seen = rst;
        if (mem_wr === 1'b1) begin
            ram[mem_a] = mem_dout;
            wr_count++;
        end
    end

    always @(negedge clk) mem_din = ram_rd(mem_a);

    always @(negedge clk) begin
        if (armed) begin
            if (rst_seen) begin
                last_instr = '0;
                last_data  = '0;
            end
            check("flag_overlap", 32'(instruction_flag & data_flag), 32'd0);
            if (instruction_flag || data_flag) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("completion_kind", 32'(instruction_flag), 32'(cmp_e.kind == K_FETCH));
                    if (cmp_e.kind == K_FETCH) last_instr = cmp_e.value;
                    else if (cmp_e.kind == K_LOAD) last_data = cmp_e.value;
                end
            end
            check("instruction", instruction, last_instr);
            check("data_value", data_value, last_data);
        end
    end

    task automatic start_req(input int kind, input logic [31:0] addr, input logic [1:0] l,
                             input logic [31:0] wv);
        exp_t        e;
        logic [31:0] v;
        int          n;
        n = nbytes(kind, l);
        v = '0;
        for (int k = 0; k < n; k++) begin
            if (kind == K_STORE) model_ram[addr + 32'(k)] = wv[8*k +: 8];
            else v[8*k +: 8] = model_rd(addr + 32'(k));
        end
        e.kind  = kind;
        e.value = v;
        exp_q.push_back(e);
        case (kind)
            K_FETCH: begin
                instruction_read_flag    = 1'b1;
                instruction_read_address = addr;
            end
            K_LOAD: begin
                data_read_flag = 1'b1;
                data_address   = addr;
                data_len       = l;
            end
            default: begin
                data_write_flag  = 1'b1;
                data_address     = addr;
                data_len         = l;
                data_write_value = wv;
            end
        endcase
    endtask

    // skip = edges expected to pass before this request is accepted
    task automatic wait_done(input int kind, input logic [31:0] addr, input int n,
                             input logic [31:0] wv, input int skip);
        int cyc;
        int k;
        int wr0;
        bit got;
        wr0 = wr_count;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            k = cyc - 1 - skip;
            if (k >= 0 && k < n) begin
                check("mem_a", mem_a, addr + 32'(k));
                if (kind == K_STORE) begin
                    check("mem_wr_store", 32'(mem_wr), 32'd1);
                    check("mem_dout", 32'(mem_dout), 32'(wv[8*k +: 8]));
                end else begin
                    check("mem_wr_read", 32'(mem_wr), 32'd0);
                end
            end
            got = (kind == K_FETCH) ? instruction_flag : data_flag;
        end
        if (!got) check("completion_timeout", 32'd0, 32'd1);
        else check("latency", 32'(cyc), 32'(n + 1 + skip));
        check("ram_writes", 32'(wr_count - wr0), (kind == K_STORE) ? 32'(n) : 32'd0);
    endtask

    task automatic finish_txn();
        instruction_read_flag = 1'b0;
        data_read_flag        = 1'b0;
        data_write_flag       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("flag_single_cycle", {30'd0, instruction_flag, data_flag}, 32'd0);
    endtask

    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [1:0] l,
                           input logic [31:0] wv);
        start_req(kind, addr, l, wv);
        wait_done(kind, addr, nbytes(kind, l), wv, 0);
        finish_txn();
    endtask

    task automatic flush_txn(input bit by_address);
        instruction_read_flag    = 1'b1;
        instruction_read_address = 32'h200;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (by_address) instruction_read_address = 32'h300;
        else instruction_read_flag = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_no_flag", 32'(instruction_flag), 32'd0);
        start_req(K_FETCH, 32'h300, 2'd3, 32'd0);
        wait_done(K_FETCH, 32'h300, 4, 32'd0, 0);
        check("flush_word_literal", instruction, 32'h00A00093);
        finish_txn();
    endtask

    initial begin
        int bad;
        int wr0;
        for (int i = 0; i < NINIT; i++) model_ram[INIT_A[i]] = INIT_D[i];
        rst                      = 1'b1;
        instruction_read_flag    = 1'b0;
        instruction_read_address = '0;
        data_read_flag           = 1'b0;
        data_write_flag          = 1'b0;
        data_address             = '0;
        data_len                 = '0;
        data_write_value         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_instruction_flag", 32'(instruction_flag), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_data_flag", 32'(data_flag), 32'd0);
        check("rst_data_value", data_value, 32'd0);

        // fetch already pending while reset is held
        start_req(K_FETCH, 32'h100, 2'd3, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("no_accept_in_reset", mem_a, 32'd0);
        rst = 1'b0;
        wait_done(K_FETCH, 32'h100, 4, 32'd0, 0);
        check("fetch_word_literal", instruction, 32'h00100513);
        finish_txn();

        run_txn(K_STORE, 32'h20, 2'd0, 32'hDEAD_BEEF);
        check("byte_store_ram", {ram_rd(32'h23), ram_rd(32'h22), ram_rd(32'h21), ram_rd(32'h20)},
              32'h4433_22EF);
        run_txn(K_LOAD, 32'h20, 2'd1, 32'd0);
        check("half_load_literal", data_value, 32'h0000_22EF);
        run_txn(K_LOAD, 32'h22, 2'd0, 32'd0);
        check("byte_load_literal", data_value, 32'h0000_0033);
        run_txn(K_LOAD, 32'h100, 2'd2, 32'd0);
        check("len2_load_literal", data_value, 32'h0010_0513);
        run_txn(K_STORE, 32'h30, 2'd1, 32'h1234_ABCD);
        run_txn(K_LOAD, 32'h30, 2'd3, 32'd0);
        check("half_store_readback", data_value, 32'hDDCC_ABCD);

        // store and load raised together: store wins, load sees new data
        start_req(K_STORE, 32'h50, 2'd3, 32'hCAFE_F00D);
        start_req(K_LOAD, 32'h50, 2'd3, 32'd0);
        wait_done(K_STORE, 32'h50, 4, 32'hCAFE_F00D, 0);
        data_write_flag = 1'b0;
        wait_done(K_LOAD, 32'h50, 4, 32'd0, 1);
        check("write_priority_literal", data_value, 32'hCAFE_F00D);
        finish_txn();

        // fetch and load raised together: load first, fetch after the DONE cycle
        start_req(K_LOAD, 32'h100, 2'd3, 32'd0);
        start_req(K_FETCH, 32'h20, 2'd3, 32'd0);
        wait_done(K_LOAD, 32'h100, 4, 32'd0, 0);
        data_read_flag = 1'b0;
        wait_done(K_FETCH, 32'h20, 4, 32'd0, 1);
        check("contention_fetch_literal", instruction, 32'h4433_22EF);
        finish_txn();

        flush_txn(1'b0);
        flush_txn(1'b1);

        // reset after two bytes of a word store
        wr0 = wr_count;
        model_ram[32'h40] = 8'h44;
        model_ram[32'h41] = 8'h33;
        data_write_flag  = 1'b1;
        data_address     = 32'h40;
        data_len         = 2'd3;
        data_write_value = 32'h1122_3344;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst             = 1'b1;
        data_write_flag = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mem_wr", 32'(mem_wr), 32'd0);
        check("reset_data_flag", 32'(data_flag), 32'd0);
        check("reset_writes", 32'(wr_count - wr0), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_no_late_writes", 32'(wr_count - wr0), 32'd2);
        run_txn(K_LOAD, 32'h40, 2'd3, 32'd0);
        check("reset_store_literal", data_value, 32'h0000_3344);

        run_txn(K_LOAD, 32'hFFFF_FFFF, 2'd1, 32'd0);
        check("wrap_half_literal", data_value, 32'h0000_CDAB);
        run_txn(K_STORE, 32'hFFFF_FFFE, 2'd3, 32'h8765_4321);
        run_txn(K_LOAD, 32'hFFFF_FFFE, 2'd3, 32'd0);
        check("wrap_word_literal", data_value, 32'h8765_4321);

        bad = 0;
        foreach (ram[a]) if (ram[a] !== model_rd(a)) bad++;
        foreach (model_ram[a]) if (model_ram[a] !== ram_rd(a)) bad++;
        check("ram_image", 32'(bad), 32'd0);
        check("pending_completions", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
